// File: rtl/cic_decimator.sv
// Three-stage CIC decimator (N=3, M=1) with runtime-selectable ratio R = 2^k.
// Output is gain-normalised by an arithmetic shift of 3*k and emitted with a one-cycle valid pulse.
module cic_decimator #(
    parameter int WIDTH     = 16,
    parameter int MAX_LOG2R = 4
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] x_n,
    input  logic [2:0]              dec_sel,
    output logic signed [WIDTH-1:0] y_n,
    output logic                    valid_out
);

    localparam int ACC_W = WIDTH + 3 * MAX_LOG2R;
    localparam logic [2:0] MAX_SEL = 3'(MAX_LOG2R);
    localparam logic [MAX_LOG2R-1:0] CNT_ONE = MAX_LOG2R'(1);
    localparam logic [MAX_LOG2R:0] RFULL_ONE = (MAX_LOG2R + 1)'(1);

    logic signed [ACC_W-1:0] r_i1, r_i2, r_i3;
    logic signed [ACC_W-1:0] r_d1, r_d2, r_d3;
    logic [MAX_LOG2R-1:0]    r_cnt;
    logic [2:0]              r_log2r;
    logic                    r_strobe;
    logic                    r_valid;
    logic signed [WIDTH-1:0] r_y;

    logic signed [ACC_W-1:0] w_x, w_i1n, w_i2n, w_i3n;
    logic signed [ACC_W-1:0] w_c1, w_c2, w_c3;
    logic [2:0]              w_sel_clamp, w_log2r;
    logic [MAX_LOG2R:0]      w_rfull;
    logic [MAX_LOG2R-1:0]    w_rm1;
    logic                    w_last;
    logic [4:0]              w_shamt;
    logic signed [WIDTH-1:0] w_y;

    assign w_x   = {{(ACC_W - WIDTH){x_n[WIDTH-1]}}, x_n};
    assign w_i1n = r_i1 + w_x;
    assign w_i2n = r_i2 + w_i1n;
    assign w_i3n = r_i3 + w_i2n;

    // The first sample of a block uses the freshly selected ratio, so R=1 closes immediately.
    assign w_sel_clamp = (dec_sel > MAX_SEL) ? MAX_SEL : dec_sel;
    assign w_log2r     = (r_cnt == '0) ? w_sel_clamp : r_log2r;
    assign w_rfull     = RFULL_ONE << w_log2r;
    assign w_rm1       = MAX_LOG2R'(w_rfull - RFULL_ONE);
    assign w_last      = (r_cnt == w_rm1);

    assign w_c1    = r_i3 - r_d1;
    assign w_c2    = w_c1 - r_d2;
    assign w_c3    = w_c2 - r_d3;
    assign w_shamt = {2'b00, r_log2r} * 5'd3;
    assign w_y     = WIDTH'(w_c3 >>> w_shamt);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_i1     <= '0;
            r_i2     <= '0;
            r_i3     <= '0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_d3     <= '0;
            r_cnt    <= '0;
            r_log2r  <= '0;
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;
            r_y      <= '0;
        end else begin
            if (enable) begin
                r_i1  <= w_i1n;
                r_i2  <= w_i2n;
                r_i3  <= w_i3n;
                r_cnt <= w_last ? '0 : r_cnt + CNT_ONE;
                if (r_cnt == '0) r_log2r <= w_sel_clamp;
            end
            r_strobe <= enable && w_last;
            r_valid  <= r_strobe;
            // Comb runs on the strobe alone; r_log2r still holds the ratio of the block being closed.
            if (r_strobe) begin
                r_d1 <= r_i3;
                r_d2 <= w_c1;
                r_d3 <= w_c2;
                r_y  <= w_y;
            end
        end
    end

    assign y_n       = r_y;
    assign valid_out = r_valid;

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: a closed-form CIC model (triple sums of the sample
// history, third differences at block ends) predicts every output and its timing.
module tb_cic_decimator;

    logic               CLK;
    logic               rst_n;
    logic               enable;
    logic signed [15:0] x_n;
    logic [2:0]         dec_sel;
    logic signed [15:0] y_n;
    logic               valid_out;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    longint      hist[$];
    longint      blk[$];
    int          m_cnt = 0;
    int          m_log2r = 0;
    logic [15:0] exp_q[$];
    int          exp_due[$];
    logic [15:0] got_q[$];
    int          got_edge[$];
    logic [15:0] cont_q[$];
    logic [15:0] m_last_y;

    cic_decimator dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .enable    (enable),
        .x_n       (x_n),
        .dec_sel   (dec_sel),
        .y_n       (y_n),
        .valid_out (valid_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input longint got, input longint req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Closed-form reference: I3 after n samples is sum x_j * C(n-1-j+2, 2); the comb output is
    // the third difference of I3 taken at block ends, wrapped to 28 bits and shifted by 3*log2R.
    task automatic model_accept(input int xv, input int sel, input int now);
        longint i3, c, b1, b2, b3, m;
        int n, nb;
        if (m_cnt == 0) m_log2r = (sel > 4) ? 4 : sel;
        hist.push_back(longint'(xv));
        m_cnt++;
        if (m_cnt == (1 << m_log2r)) begin
            m_cnt = 0;
            n = hist.size();
            i3 = 0;
            for (int j = 0; j < n; j++) begin
                m = longint'(n - 1 - j);
                i3 += hist[j] * (((m + 2) * (m + 1)) / 2);
            end
            blk.push_back(i3);
            nb = blk.size();
            b1 = (nb >= 2) ? blk[nb-2] : 0;
            b2 = (nb >= 3) ? blk[nb-3] : 0;
            b3 = (nb >= 4) ? blk[nb-4] : 0;
            c = i3 - 3 * b1 + 3 * b2 - b3;
            c = (c <<< 36) >>> 36;
            c = c >>> (3 * m_log2r);
            m_last_y = c[15:0];
            exp_q.push_back(c[15:0]);
            exp_due.push_back(now + 2);
        end
    endtask

    always @(negedge CLK) begin
        logic exp_v;
        exp_v = (exp_due.size() > 0) && (exp_due[0] == edge_cnt);
        total++;
        if (valid_out !== exp_v) begin
            bad++;
            $display("FAIL valid_out @edge %0d: got %0b, required %0b", edge_cnt, valid_out, exp_v);
        end
        if (exp_v) begin
            total++;
            if (y_n !== exp_q[0]) begin
                bad++;
                $display("FAIL y_n @edge %0d: got %0d, required %0d", edge_cnt, y_n, $signed(exp_q[0]));
            end
            void'(exp_q.pop_front());
            void'(exp_due.pop_front());
        end
        if (valid_out === 1'b1) begin
            got_q.push_back(y_n);
            got_edge.push_back(edge_cnt);
        end
    end

    task automatic drive(input logic en, input int xv, input int sel);
        @(posedge CLK);
        #1;
        enable  = en;
        x_n     = 16'(xv);
        dec_sel = 3'(sel);
        if (en) model_accept(xv, sel, edge_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        hist.delete();
        blk.delete();
        exp_q.delete();
        exp_due.delete();
        got_q.delete();
        got_edge.delete();
        m_cnt = 0;
        m_log2r = 0;
        #1;
        chk("reset_y", longint'(y_n), 0);
        chk("reset_valid", longint'(valid_out), 0);
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_due.size() > 0; i++) idle(1);
        chk("drain_pending", longint'(exp_due.size()), 0);
    endtask

    task automatic chk_spacing(input string name, input int first, input int step);
        for (int k = first; k < got_edge.size(); k++)
            chk(name, longint'(got_edge[k] - got_edge[k-1]), longint'(step));
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        x_n     = '0;
        dec_sel = '0;
        do_reset();

        // Reset mid-block at R=16: 37 samples, then 16 fresh samples before the next output.
        for (int i = 0; i < 37; i++) drive(1'b1, int'($signed(16'($urandom))), 4);
        idle(3);
        chk("pre_reset_outputs", longint'(got_q.size()), 2);
        do_reset();
        for (int i = 0; i < 15; i++) drive(1'b1, int'($signed(16'($urandom))), 4);
        idle(4);
        chk("no_early_output", longint'(got_q.size()), 0);
        drive(1'b1, 1234, 4);
        idle(3);
        chk("output_after_16", longint'(got_q.size()), 1);

        // DC at R=4.
        do_reset();
        for (int i = 0; i < 40; i++) drive(1'b1, 16384, 2);
        drain();
        chk("dc4_count", longint'(got_q.size()), 10);
        chk("dc4_model", longint'($signed(m_last_y)), 16384);
        for (int k = 3; k < got_q.size(); k++) chk("dc4_value", longint'($signed(got_q[k])), 16384);
        chk_spacing("dc4_spacing", 1, 4);

        // Bypass R=1 with a ramp.
        do_reset();
        for (int i = 0; i < 40; i++) drive(1'b1, i, 0);
        drain();
        chk("bypass_count", longint'(got_q.size()), 40);
        for (int k = 3; k < got_q.size(); k++) chk("bypass_value", longint'($signed(got_q[k])), longint'(k));
        chk_spacing("bypass_spacing", 1, 1);

        // Negative full scale, R=16, long enough for the integrators to wrap.
        do_reset();
        for (int i = 0; i < 2000; i++) drive(1'b1, -32768, 4);
        drain();
        chk("negfs_count", longint'(got_q.size()), 125);
        chk("negfs_model", longint'($signed(m_last_y)), -32768);
        for (int k = 3; k < got_q.size(); k++) chk("negfs_value", longint'($signed(got_q[k])), -32768);
        chk_spacing("negfs_spacing", 1, 16);

        // Enable gaps at R=2 must give the same output sequence as continuous enable.
        do_reset();
        for (int i = 0; i < 24; i++) drive(1'b1, 1000, 1);
        drain();
        cont_q = got_q;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1000, 1);
            idle($urandom_range(0, 2));
        end
        drain();
        chk("gap_count", longint'(got_q.size()), longint'(cont_q.size()));
        for (int k = 0; k < got_q.size() && k < cont_q.size(); k++)
            chk("gap_vs_cont", longint'($signed(got_q[k])), longint'($signed(cont_q[k])));
        for (int k = 3; k < got_q.size(); k++) chk("gap_value", longint'($signed(got_q[k])), 1000);

        // Ratio change R=4 -> R=8 requested at cnt=2 of the third block.
        do_reset();
        for (int i = 0; i < 60; i++) drive(1'b1, 8192, (i < 10) ? 2 : 3);
        drain();
        chk("ratio_count", longint'(got_q.size()), 9);
        if (got_edge.size() == 9) begin
            chk("ratio_gap_r4a", longint'(got_edge[1] - got_edge[0]), 4);
            chk("ratio_gap_r4b", longint'(got_edge[2] - got_edge[1]), 4);
            chk_spacing("ratio_spacing_r8", 3, 8);
            for (int k = 6; k < 9; k++) chk("ratio_settled", longint'($signed(got_q[k])), 8192);
        end

        // Randomised enable, data and ratio (including clamped codes 5..7).
        do_reset();
        begin
            int sel;
            sel = $urandom_range(0, 7);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 15) == 0) sel = $urandom_range(0, 7);
                drive($urandom_range(0, 3) != 0, int'($signed(16'($urandom))), sel);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
